// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a fetch and a load/store requester,
// with stall locking, fetch anti-starvation and an owner-tagged read return pipeline.
module mem_port_arbiter #(
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_gnt,
    output logic        f_rdvalid,
    output logic [15:0] f_rddata,
    input  logic        l_rd,
    input  logic        l_wr,
    input  logic [15:0] l_addr,
    input  logic [15:0] l_wrdata,
    output logic        l_gnt,
    output logic        l_rdvalid,
    output logic [15:0] l_rddata,
    output logic [15:0] m_addr,
    output logic [15:0] m_wrdata,
    output logic        m_rd,
    output logic        m_wr,
    input  logic        m_waitreq,
    input  logic [15:0] m_rddata,
    output logic        proto_err
);
    typedef enum logic [1:0] {IDLE, LOCK_F, LOCK_L} state_t;
    typedef enum logic [1:0] {O_NONE, O_F, O_L} owner_t;

    state_t            state_q, state_d;
    owner_t            owner;
    logic [3:0]        starve_q, starve_d;
    logic              proto_err_q, proto_err_d;
    logic [RD_LAT-1:0] tv_q, tv_d, tl_q, tl_d;
    logic              l_act, f_win, accept;

    always_comb begin
        l_act = l_rd | l_wr;
        f_win = f_req && (starve_q == 4'(STARVE_LIMIT));
        owner = O_NONE;
        // Nothing is presented while reset is asserted, so every strobe is low during reset.
        if (rst_n) begin
            if (state_q == LOCK_F)
                owner = f_req ? O_F : O_NONE;
            else if (state_q == LOCK_L)
                owner = l_act ? O_L : O_NONE;
            else
                owner = f_win ? O_F : l_act ? O_L : f_req ? O_F : O_NONE;
        end
        accept   = (owner != O_NONE) && !m_waitreq;
        f_gnt    = accept && (owner == O_F);
        l_gnt    = accept && (owner == O_L);
        m_addr   = (owner == O_F) ? f_addr : (owner == O_L) ? l_addr : 16'h0000;
        m_wrdata = (owner == O_L) ? l_wrdata : 16'h0000;
        m_rd     = (owner == O_F) || ((owner == O_L) && l_rd && !l_wr);
        m_wr     = (owner == O_L) && l_wr;
        // A stalled owner stays locked; accept or a withdrawn request falls back to IDLE.
        state_d  = (owner == O_NONE || accept) ? IDLE : (owner == O_F) ? LOCK_F : LOCK_L;
        starve_d = (f_req && !f_gnt) ? (f_win ? starve_q : starve_q + 4'd1) : 4'd0;
        proto_err_d = proto_err_q | (l_rd & l_wr);
        tv_d = RD_LAT'({tv_q, accept & m_rd});
        tl_d = RD_LAT'({tl_q, owner == O_L});
        f_rdvalid = tv_q[RD_LAT-1] & ~tl_q[RD_LAT-1];
        l_rdvalid = tv_q[RD_LAT-1] & tl_q[RD_LAT-1];
        f_rddata  = m_rddata;
        l_rddata  = m_rddata;
        proto_err = proto_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= 4'd0;
            proto_err_q <= 1'b0;
            tv_q        <= '0;
            tl_q        <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            proto_err_q <= proto_err_d;
            tv_q        <= tv_d;
            tl_q        <= tl_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus pushes expected grants/read returns into queues;
// a negedge monitor pops and compares whenever the DUT grants or returns read data.
module tb_mem_port_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0, rst1_n = 1'b0;
    logic        f_req, l_rd, l_wr, m_waitreq;
    logic [15:0] f_addr, l_addr, l_wrdata, m_rddata;
    logic        f_gnt, f_rdvalid, l_gnt, l_rdvalid, m_rd, m_wr, proto_err;
    logic [15:0] f_rddata, l_rddata, m_addr, m_wrdata;
    logic        f_gnt1, f_rdvalid1, l_gnt1, l_rdvalid1, m_rd1, m_wr1, proto_err1;
    logic [15:0] f_rddata1, l_rddata1, m_addr1, m_wrdata1;
    int          cyc = 0;
    int          tests = 0, fails = 0;

    typedef struct {int c; bit is_l; logic [15:0] a; bit rd; bit wr; logic [15:0] d;} gnt_t;
    typedef struct {int c; bit is_l; logic [15:0] d;} rdv_t;
    gnt_t gq[$];
    rdv_t rq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Memory returns a cycle-stamped word so data and latency are both checked.
    assign m_rddata = 16'(cyc) ^ 16'hA5A5;

    mem_port_arbiter #(.RD_LAT(1), .STARVE_LIMIT(4)) u0 (
        .clk(clk), .rst_n(rst_n), .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rdvalid(f_rdvalid), .f_rddata(f_rddata), .l_rd(l_rd), .l_wr(l_wr),
        .l_addr(l_addr), .l_wrdata(l_wrdata), .l_gnt(l_gnt), .l_rdvalid(l_rdvalid),
        .l_rddata(l_rddata), .m_addr(m_addr), .m_wrdata(m_wrdata), .m_rd(m_rd),
        .m_wr(m_wr), .m_waitreq(m_waitreq), .m_rddata(m_rddata), .proto_err(proto_err));

    mem_port_arbiter #(.RD_LAT(3), .STARVE_LIMIT(4)) u1 (
        .clk(clk), .rst_n(rst1_n), .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt1),
        .f_rdvalid(f_rdvalid1), .f_rddata(f_rddata1), .l_rd(l_rd), .l_wr(l_wr),
        .l_addr(l_addr), .l_wrdata(l_wrdata), .l_gnt(l_gnt1), .l_rdvalid(l_rdvalid1),
        .l_rddata(l_rddata1), .m_addr(m_addr1), .m_wrdata(m_wrdata1), .m_rd(m_rd1),
        .m_wr(m_wr1), .m_waitreq(m_waitreq), .m_rddata(m_rddata), .proto_err(proto_err1));

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cyc %0d: got 0x%0h, want 0x%0h", n, cyc, act, exp);
        end
    endtask

    task automatic drv(bit f, logic [15:0] fa, bit lr, bit lw, logic [15:0] la,
                       logic [15:0] ld, bit wq);
        f_req = f; f_addr = fa; l_rd = lr; l_wr = lw; l_addr = la; l_wrdata = ld; m_waitreq = wq;
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic eg(bit l, logic [15:0] a, bit rd, bit wr, logic [15:0] d);
        gq.push_back('{cyc, l, a, rd, wr, d});
    endtask

    task automatic er(bit l, int c);
        rq.push_back('{c, l, 16'(c) ^ 16'hA5A5});
    endtask

    always @(negedge clk) begin
        gnt_t g;
        rdv_t r;
        if (rst_n) begin
            if (f_gnt || l_gnt) begin
                chk("gnt_onehot", 32'(f_gnt & l_gnt), 0);
                if (gq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_gnt at cyc %0d: got f=%b l=%b, want none", cyc, f_gnt, l_gnt);
                end else begin
                    g = gq.pop_front();
                    chk("gnt_cyc", cyc, g.c);
                    chk("gnt_owner_l", 32'(l_gnt), 32'(g.is_l));
                    chk("m_addr", 32'(m_addr), 32'(g.a));
                    chk("m_rd", 32'(m_rd), 32'(g.rd));
                    chk("m_wr", 32'(m_wr), 32'(g.wr));
                    if (g.wr) chk("m_wrdata", 32'(m_wrdata), 32'(g.d));
                end
            end
            if (f_rdvalid || l_rdvalid) begin
                chk("rdv_onehot", 32'(f_rdvalid & l_rdvalid), 0);
                if (rq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_rdvalid at cyc %0d: got f=%b l=%b, want none", cyc, f_rdvalid, l_rdvalid);
                end else begin
                    r = rq.pop_front();
                    chk("rdv_cyc", cyc, r.c);
                    chk("rdv_owner_l", 32'(l_rdvalid), 32'(r.is_l));
                    chk("rddata", 32'(l_rdvalid ? l_rddata : f_rddata), 32'(r.d));
                end
            end
        end
    end

    initial begin
        drv(1, 16'h0011, 1, 0, 16'h0022, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_f_gnt", 32'(f_gnt), 0);
        chk("rst_l_gnt", 32'(l_gnt), 0);
        chk("rst_m_rd", 32'(m_rd), 0);
        chk("rst_m_wr", 32'(m_wr), 0);
        chk("rst_m_addr", 32'(m_addr), 0);
        chk("rst_rdvalid", 32'({f_rdvalid, l_rdvalid}), 0);
        chk("rst_proto_err", 32'(proto_err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0);
        nxt;
        // single fetch
        drv(1, 16'h0010, 0, 0, 0, 0, 0); eg(0, 16'h0010, 1, 0, 0); er(0, cyc + 1); nxt;
        drv(0, 0, 0, 0, 0, 0, 0); nxt;
        // contention: four loads, forced fetch, load resumes
        drv(1, 16'h0020, 1, 0, 16'h8000, 0, 0);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin eg(1, 16'h8000, 1, 0, 0); er(1, cyc + 1); end
            else begin eg(0, 16'h0020, 1, 0, 0); er(0, cyc + 1); end
            nxt;
        end
        drv(0, 0, 1, 0, 16'h8000, 0, 0); eg(1, 16'h8000, 1, 0, 0); er(1, cyc + 1); nxt;
        drv(0, 0, 0, 0, 0, 0, 0); nxt;
        // load stalled 3 cycles, fetch arrives mid-stall
        drv(0, 0, 1, 0, 16'h0200, 0, 1); nxt;
        drv(1, 16'h0030, 1, 0, 16'h0200, 0, 1);
        @(negedge clk); chk("stall_addr1", 32'(m_addr), 32'h0200); nxt;
        @(negedge clk); chk("stall_addr2", 32'(m_addr), 32'h0200); nxt;
        drv(1, 16'h0030, 1, 0, 16'h0200, 0, 0); eg(1, 16'h0200, 1, 0, 0); er(1, cyc + 1); nxt;
        drv(1, 16'h0030, 0, 0, 0, 0, 0); eg(0, 16'h0030, 1, 0, 0); er(0, cyc + 1); nxt;
        drv(0, 0, 0, 0, 0, 0, 0); nxt;
        // fetch stalled and locked; a load arriving meanwhile must wait
        drv(1, 16'h0058, 0, 0, 0, 0, 1); nxt;
        drv(1, 16'h0058, 1, 0, 16'h0300, 0, 1);
        @(negedge clk); chk("lockf_addr", 32'(m_addr), 32'h0058); nxt;
        drv(1, 16'h0058, 1, 0, 16'h0300, 0, 0); eg(0, 16'h0058, 1, 0, 0); er(0, cyc + 1); nxt;
        drv(0, 0, 1, 0, 16'h0300, 0, 0); eg(1, 16'h0300, 1, 0, 0); er(1, cyc + 1); nxt;
        drv(0, 0, 0, 0, 0, 0, 0); nxt;
        // locked fetch withdrawn: no strobe, back to IDLE
        drv(1, 16'h0050, 0, 0, 0, 0, 1); nxt;
        drv(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); chk("withdraw_m_rd", 32'(m_rd), 0); nxt;
        drv(0, 0, 1, 0, 16'h0060, 0, 0); eg(1, 16'h0060, 1, 0, 0); er(1, cyc + 1); nxt;
        drv(0, 0, 0, 0, 0, 0, 0); nxt;
        // store
        drv(0, 0, 0, 1, 16'h0100, 16'hBEEF, 0); eg(1, 16'h0100, 0, 1, 16'hBEEF); nxt;
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("proto_err_clear", 32'(proto_err), 0); nxt;
        // read+write together
        drv(0, 0, 1, 1, 16'h0104, 16'h1234, 0); eg(1, 16'h0104, 0, 1, 16'h1234); nxt;
        drv(0, 0, 0, 0, 0, 0, 0); nxt; nxt;
        @(negedge clk); chk("proto_err_sticky", 32'(proto_err), 1); nxt;
        nxt;
        chk("gq_empty", gq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        rst_n = 1'b0;
        @(negedge clk); chk("rst_clears_proto_err", 32'(proto_err), 0); nxt;
        // reset during an in-flight RD_LAT=3 read
        rst1_n = 1'b1; nxt;
        drv(1, 16'h0040, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("u1_f_gnt", 32'(f_gnt1), 1);
        chk("u1_m_addr", 32'(m_addr1), 32'h0040);
        nxt;
        rst1_n = 1'b0;
        @(negedge clk);
        chk("u1_rst_gnt", 32'({f_gnt1, l_gnt1}), 0);
        chk("u1_rst_strobe", 32'({m_rd1, m_wr1}), 0);
        chk("u1_rst_m_addr", 32'(m_addr1), 0);
        chk("u1_rst_rdvalid", 32'({f_rdvalid1, l_rdvalid1}), 0);
        nxt;
        rst1_n = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("u1_no_rdvalid", 32'({f_rdvalid1, l_rdvalid1}), 0); nxt;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, memory read latency in cycles (legal 1..4).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive fetch-loss cycles before fetch is forced to win (legal 1..15).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-005 f_req  in  1  fetch read request; held with f_addr stable until f_gnt.
REQ-006 f_addr  in  16  fetch address.
REQ-007 f_gnt  out  1  fetch command accepted this cycle.
REQ-008 f_rdvalid  out  1  fetch read data valid on f_rddata.
REQ-009 f_rddata  out  16  fetch read data (= m_rddata).
REQ-010 l_rd / l_wr  in  1 each  load / store request; held with l_addr, l_wrdata stable until l_gnt.
REQ-011 l_addr, l_wrdata  in  16 each  load/store address, store data.
REQ-012 l_gnt  out  1  load/store command accepted this cycle.
REQ-013 l_rdvalid  out  1  load read data valid on l_rddata.
REQ-014 l_rddata  out  16  load read data (= m_rddata).
REQ-015 m_addr, m_wrdata  out  16 each  shared memory address, write data.
REQ-016 m_rd, m_wr  out  1 each  shared memory read/write strobes.
REQ-017 m_waitreq  in  1  memory stall; command presented while high is not accepted.
REQ-018 m_rddata  in  16  memory read data, valid RD_LAT cycles after an accepted m_rd.
REQ-019 proto_err  out  1  sticky: l_rd and l_wr seen high together.

Function
REQ-020 Requester L active = l_rd | l_wr; requester F active = f_req.
REQ-021 FSM states IDLE, LOCK_F, LOCK_L; owner presented to memory is: IDLE -> arbitration winner; LOCK_F -> F; LOCK_L -> L.
REQ-022 Arbitration in IDLE: L wins over F, except F wins when starve_cnt == STARVE_LIMIT and f_req high.
REQ-023 m_addr/m_rd/m_wr/m_wrdata SHALL be combinational from the presented owner; all zero when no owner.
REQ-024 Accept = owner presented & !m_waitreq; f_gnt/l_gnt = accept for respective owner; never both high.
REQ-025 IDLE -> LOCK_x when owner x presented and m_waitreq high; LOCK_x -> IDLE on accept; no owner switch while locked.
REQ-026 In LOCK_x, withdrawn request of x (protocol violation) SHALL return FSM to IDLE next cycle, no grant.
REQ-027 l_rd and l_wr together: treated as write only; proto_err set, cleared only by reset.
REQ-028 starve_cnt (4 bits): +1 each cycle f_req high and f_gnt low, saturating at STARVE_LIMIT; cleared on f_gnt or f_req low.
REQ-029 Read tag pipeline RD_LAT deep: entry {valid, owner} pushed each cycle; valid = accepted m_rd.
REQ-030 f_rdvalid/l_rdvalid = valid at tag pipeline output with matching owner, exactly RD_LAT cycles after grant; never both.
REQ-031 Writes SHALL generate no rdvalid; back-to-back accepted reads SHALL return in order, one per cycle.
REQ-032 Zero-cycle handoff: accept of one owner and new arbitration for the next command in the following cycle, no bubble required.

Reset
REQ-033 On reset low: FSM IDLE, starve_cnt 0, tag pipeline cleared, proto_err 0; f_gnt, l_gnt, rdvalids, m_rd, m_wr 0 during reset.
REQ-034 Reads in flight at reset SHALL produce no rdvalid after reset release.

Verification
REQ-035 Single fetch: f_req=1, f_addr=0x0010, m_waitreq=0 -> f_gnt=1 same cycle, m_rd=1, m_addr=0x0010; f_rdvalid=1 with m_rddata 1 cycle later (RD_LAT=1).
REQ-036 Contention: f_req and l_rd both held, l_addr=0x8000 -> L granted 4 cycles in a row, 5th cycle f_gnt=1, then L resumes.
REQ-037 Stall lock: L presented, m_waitreq high 3 cycles, f_req rises mid-stall -> m_addr stays l_addr, l_gnt on 4th cycle, f_gnt next cycle.
REQ-038 Store: l_wr=1, l_addr=0x0100, l_wrdata=0xBEEF -> m_wr=1, m_wrdata=0xBEEF, l_gnt=1, no l_rdvalid ever.
REQ-039 Protocol error: l_rd=l_wr=1 -> m_wr=1, m_rd=0, proto_err=1 held until reset.
REQ-040 Reset mid-read: RD_LAT=3, fetch granted, reset pulsed low next cycle -> no f_rdvalid afterward, all outputs 0 during reset.
